// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard event decoder: event kinds,
// scan-code constants and the scan-code to ASCII mapping functions.
package ps2_pkg;

    typedef enum logic [2:0] {
        KIND_SYMBOL    = 3'd0,
        KIND_LEFT      = 3'd1,
        KIND_RIGHT     = 3'd2,
        KIND_BACKSPACE = 3'd3,
        KIND_ENTER     = 3'd4,
        KIND_DELETE    = 3'd5,
        KIND_HOME      = 3'd6,
        KIND_END       = 3'd7
    } kind_e;

    // Modifier keys
    localparam logic [15:0] SC_LSHIFT   = 16'h0012;
    localparam logic [15:0] SC_RSHIFT   = 16'h0059;
    localparam logic [15:0] SC_CAPS     = 16'h0058;
    // Editing / navigation keys
    localparam logic [15:0] SC_LEFT     = 16'hE06B;
    localparam logic [15:0] SC_RIGHT    = 16'hE074;
    localparam logic [15:0] SC_BKSP     = 16'h0066;
    localparam logic [15:0] SC_ENTER    = 16'h005A;
    localparam logic [15:0] SC_KP_ENTER = 16'hE05A;
    localparam logic [15:0] SC_DELETE   = 16'hE071;
    localparam logic [15:0] SC_HOME     = 16'hE06C;
    localparam logic [15:0] SC_END      = 16'hE069;
    localparam logic [15:0] SC_KP_SLASH = 16'hE04A;
    localparam logic [15:0] SC_SPACE    = 16'h0029;

    // Queue entry is {kind, symbol}
    localparam int EVENT_W = 10;

    typedef struct packed {
        logic       hit;
        kind_e      kind;
        logic [6:0] sym;
    } key_event_t;

    // Letter keys: returns {hit, lowercase ASCII}
    function automatic logic [7:0] letter_lc(input logic [7:0] code);
        logic [7:0] r;
        case (code)
            8'h1C: r = {1'b1, 7'h61}; // a
            8'h32: r = {1'b1, 7'h62}; // b
            8'h21: r = {1'b1, 7'h63}; // c
            8'h23: r = {1'b1, 7'h64}; // d
            8'h24: r = {1'b1, 7'h65}; // e
            8'h2B: r = {1'b1, 7'h66}; // f
            8'h34: r = {1'b1, 7'h67}; // g
            8'h33: r = {1'b1, 7'h68}; // h
            8'h43: r = {1'b1, 7'h69}; // i
            8'h3B: r = {1'b1, 7'h6A}; // j
            8'h42: r = {1'b1, 7'h6B}; // k
            8'h4B: r = {1'b1, 7'h6C}; // l
            8'h3A: r = {1'b1, 7'h6D}; // m
            8'h31: r = {1'b1, 7'h6E}; // n
            8'h44: r = {1'b1, 7'h6F}; // o
            8'h4D: r = {1'b1, 7'h70}; // p
            8'h15: r = {1'b1, 7'h71}; // q
            8'h2D: r = {1'b1, 7'h72}; // r
            8'h1B: r = {1'b1, 7'h73}; // s
            8'h2C: r = {1'b1, 7'h74}; // t
            8'h3C: r = {1'b1, 7'h75}; // u
            8'h2A: r = {1'b1, 7'h76}; // v
            8'h1D: r = {1'b1, 7'h77}; // w
            8'h22: r = {1'b1, 7'h78}; // x
            8'h35: r = {1'b1, 7'h79}; // y
            8'h1A: r = {1'b1, 7'h7A}; // z
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Top-row digits and punctuation: shift selects the upper legend,
    // Caps Lock has no effect. Returns {hit, ASCII}.
    function automatic logic [7:0] shift_map(input logic [7:0] code, input logic shift);
        logic [6:0] lo;
        logic [6:0] hi;
        logic       hit;
        hit = 1'b1;
        case (code)
            8'h16: begin lo = 7'h31; hi = 7'h21; end // 1 !
            8'h1E: begin lo = 7'h32; hi = 7'h40; end // 2 @
            8'h26: begin lo = 7'h33; hi = 7'h23; end // 3 #
            8'h25: begin lo = 7'h34; hi = 7'h24; end // 4 $
            8'h2E: begin lo = 7'h35; hi = 7'h25; end // 5 %
            8'h36: begin lo = 7'h36; hi = 7'h5E; end // 6 ^
            8'h3D: begin lo = 7'h37; hi = 7'h26; end // 7 &
            8'h3E: begin lo = 7'h38; hi = 7'h2A; end // 8 *
            8'h46: begin lo = 7'h39; hi = 7'h28; end // 9 (
            8'h45: begin lo = 7'h30; hi = 7'h29; end // 0 )
            8'h4E: begin lo = 7'h2D; hi = 7'h5F; end // - _
            8'h55: begin lo = 7'h3D; hi = 7'h2B; end // = +
            8'h54: begin lo = 7'h5B; hi = 7'h7B; end // [ {
            8'h5B: begin lo = 7'h5D; hi = 7'h7D; end // ] }
            8'h4C: begin lo = 7'h3B; hi = 7'h3A; end // ; :
            8'h41: begin lo = 7'h2C; hi = 7'h3C; end // , <
            8'h49: begin lo = 7'h2E; hi = 7'h3E; end // . >
            8'h4A: begin lo = 7'h2F; hi = 7'h3F; end // / ?
            8'h29: begin lo = 7'h20; hi = 7'h20; end // space
            default: begin lo = 7'h00; hi = 7'h00; hit = 1'b0; end
        endcase
        return {hit, (shift ? hi : lo)};
    endfunction

    // Keypad keys (plain codes): fixed characters, no shift/caps effect
    function automatic logic [7:0] keypad_char(input logic [7:0] code);
        logic [7:0] r;
        case (code)
            8'h70: r = {1'b1, 7'h30}; // 0
            8'h69: r = {1'b1, 7'h31}; // 1
            8'h72: r = {1'b1, 7'h32}; // 2
            8'h7A: r = {1'b1, 7'h33}; // 3
            8'h6B: r = {1'b1, 7'h34}; // 4
            8'h73: r = {1'b1, 7'h35}; // 5
            8'h74: r = {1'b1, 7'h36}; // 6
            8'h6C: r = {1'b1, 7'h37}; // 7
            8'h75: r = {1'b1, 7'h38}; // 8
            8'h7D: r = {1'b1, 7'h39}; // 9
            8'h71: r = {1'b1, 7'h2E}; // .
            8'h7C: r = {1'b1, 7'h2A}; // *
            8'h7B: r = {1'b1, 7'h2D}; // -
            8'h79: r = {1'b1, 7'h2B}; // +
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Full classification of one make code into a queue event
    function automatic key_event_t classify_key(input logic [15:0] code,
                                                input logic        shift,
                                                input logic        caps);
        key_event_t ev;
        logic [7:0] lt;
        logic [7:0] pm;
        logic [7:0] kp;
        ev = '{hit: 1'b0, kind: KIND_SYMBOL, sym: 7'h00};
        lt = letter_lc(code[7:0]);
        pm = shift_map(code[7:0], shift);
        kp = keypad_char(code[7:0]);
        case (code)
            SC_LEFT:     ev = '{hit: 1'b1, kind: KIND_LEFT,      sym: 7'h00};
            SC_RIGHT:    ev = '{hit: 1'b1, kind: KIND_RIGHT,     sym: 7'h00};
            SC_BKSP:     ev = '{hit: 1'b1, kind: KIND_BACKSPACE, sym: 7'h00};
            SC_ENTER,
            SC_KP_ENTER: ev = '{hit: 1'b1, kind: KIND_ENTER,     sym: 7'h00};
            SC_DELETE:   ev = '{hit: 1'b1, kind: KIND_DELETE,    sym: 7'h00};
            SC_HOME:     ev = '{hit: 1'b1, kind: KIND_HOME,      sym: 7'h00};
            SC_END:      ev = '{hit: 1'b1, kind: KIND_END,       sym: 7'h00};
            SC_KP_SLASH: ev = '{hit: 1'b1, kind: KIND_SYMBOL,    sym: 7'h2F};
            default: begin
                if (code[15:8] != 8'h00) begin
                    ev.hit = 1'b0;
                end else if (lt[7]) begin
                    ev.hit = 1'b1;
                    ev.sym = (shift ^ caps) ? (lt[6:0] - 7'h20) : lt[6:0];
                end else if (pm[7]) begin
                    ev.hit = 1'b1;
                    ev.sym = pm[6:0];
                end else if (kp[7]) begin
                    ev.hit = 1'b1;
                    ev.sym = kp[6:0];
                end else begin
                    ev.hit = 1'b0;
                end
            end
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous FIFO with full/empty flags; a push while full is accepted
// only when a pop happens in the same cycle.
module key_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == {CW{1'b0}});
    assign data_o  = mem_q[rd_ptr_q];

    // Qualify push/pop and compute next pointers and occupancy
    always_comb begin
        rd_en_s  = pop_i & ~empty_o;
        wr_en_s  = push_i & (~full_o | rd_en_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard event decoder: tracks Shift/Caps state, turns make codes
// into {kind, ASCII} events through a two-stage pipeline and queues them.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter bit CAPS_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] key,
    input  logic        key_pressed,
    input  logic        new_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_kind,
    output logic [6:0]  out_symbol,
    output logic        caps_lock,
    output logic        overflow,
    input  logic        overflow_clr
);
    // Modifier state
    logic lshift_q, lshift_d;
    logic rshift_q, rshift_d;
    logic caps_held_q, caps_held_d;
    logic caps_lock_q, caps_lock_d;

    // Stage 1: captured key plus modifier snapshot
    logic        s1_valid_q, s1_valid_d;
    logic [15:0] s1_key_q, s1_key_d;
    logic        s1_pressed_q, s1_pressed_d;
    logic        s1_shift_q, s1_shift_d;
    logic        s1_caps_q, s1_caps_d;

    // Stage 2: classified event ready for the queue
    logic        s2_valid_q, s2_valid_d;
    kind_e       s2_kind_q, s2_kind_d;
    logic [6:0]  s2_sym_q, s2_sym_d;
    key_event_t  ev_s;

    logic        overflow_q, overflow_d;

    logic [EVENT_W-1:0] head_s;
    logic               full_s;
    logic               empty_s;
    logic               pop_s;

    assign out_valid  = ~empty_s;
    assign out_kind   = empty_s ? 3'd0 : head_s[9:7];
    assign out_symbol = empty_s ? 7'd0 : head_s[6:0];
    assign caps_lock  = caps_lock_q;
    assign overflow   = overflow_q;
    assign pop_s      = out_valid & out_ready;

    // Shift/Caps tracking; Caps toggles only on the first make of a press
    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_held_d = caps_held_q;
        caps_lock_d = caps_lock_q;
        if (new_key) begin
            case (key)
                SC_LSHIFT: lshift_d = key_pressed;
                SC_RSHIFT: rshift_d = key_pressed;
                SC_CAPS: begin
                    caps_held_d = key_pressed;
                    if (key_pressed && !caps_held_q) begin
                        caps_lock_d = CAPS_ENABLE ? ~caps_lock_q : 1'b0;
                    end else begin
                        caps_lock_d = caps_lock_q;
                    end
                end
                default: lshift_d = lshift_q;
            endcase
        end else begin
            lshift_d = lshift_q;
        end
    end

    // Stage 1 capture with the modifier state in effect before this key
    always_comb begin
        s1_valid_d   = new_key;
        s1_key_d     = s1_key_q;
        s1_pressed_d = s1_pressed_q;
        s1_shift_d   = s1_shift_q;
        s1_caps_d    = s1_caps_q;
        if (new_key) begin
            s1_key_d     = key;
            s1_pressed_d = key_pressed;
            s1_shift_d   = lshift_q | rshift_q;
            s1_caps_d    = caps_lock_q;
        end else begin
            s1_key_d     = s1_key_q;
        end
    end

    // Stage 2 classification: only recognised makes become events
    always_comb begin
        ev_s       = classify_key(s1_key_q, s1_shift_q, s1_caps_q);
        s2_valid_d = s1_valid_q & s1_pressed_q & ev_s.hit;
        s2_kind_d  = ev_s.kind;
        s2_sym_d   = ev_s.sym;
    end

    // Sticky overflow: a new drop wins over a concurrent clear
    always_comb begin
        overflow_d = overflow_q;
        if (s2_valid_q && full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Modifier and overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_held_q <= 1'b0;
            caps_lock_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_held_q <= caps_held_d;
            caps_lock_q <= caps_lock_d;
            overflow_q  <= overflow_d;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_key_q     <= 16'h0000;
            s1_pressed_q <= 1'b0;
            s1_shift_q   <= 1'b0;
            s1_caps_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_kind_q    <= KIND_SYMBOL;
            s2_sym_q     <= 7'h00;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_key_q     <= s1_key_d;
            s1_pressed_q <= s1_pressed_d;
            s1_shift_q   <= s1_shift_d;
            s1_caps_q    <= s1_caps_d;
            s2_valid_q   <= s2_valid_d;
            s2_kind_q    <= s2_kind_d;
            s2_sym_q     <= s2_sym_d;
        end
    end

    key_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s2_valid_q),
        .data_i  ({s2_kind_q, s2_sym_q}),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed self-checking bench for ps2_keyboard.
module tb_ps2_keyboard;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] key;
    logic        key_pressed;
    logic        new_key;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_kind;
    logic [6:0]  out_symbol;
    logic        caps_lock;
    logic        overflow;
    logic        overflow_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_keyboard #(
        .FIFO_DEPTH  (DEPTH),
        .CAPS_ENABLE (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key          (key),
        .key_pressed  (key_pressed),
        .new_key      (new_key),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_kind     (out_kind),
        .out_symbol   (out_symbol),
        .caps_lock    (caps_lock),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe one scan code; returns 1 time unit after the strobe edge
    task automatic send(input logic [15:0] code, input logic make);
        key         = code;
        key_pressed = make;
        new_key     = 1'b1;
        tick();
        new_key     = 1'b0;
        key         = 16'h0000;
        key_pressed = 1'b0;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic pop_expect(input string tag, input logic [2:0] kind, input logic [6:0] sym);
        check_eq({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
        check_eq({tag, "_kind"}, {13'd0, out_kind}, {13'd0, kind});
        check_eq({tag, "_sym"}, {9'd0, out_symbol}, {9'd0, sym});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic expect_empty(input string tag);
        check_eq({tag, "_empty"}, {15'd0, out_valid}, 16'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        key          = 16'h0000;
        key_pressed  = 1'b0;
        new_key      = 1'b0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        #3;
        check_eq("rst_valid", {15'd0, out_valid}, 16'd0);
        check_eq("rst_kind", {13'd0, out_kind}, 16'd0);
        check_eq("rst_sym", {9'd0, out_symbol}, 16'd0);
        check_eq("rst_caps", {15'd0, caps_lock}, 16'd0);
        check_eq("rst_ovf", {15'd0, overflow}, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Plain letter and its latency
        send(16'h001C, 1'b1);
        check_eq("lat_e0", {15'd0, out_valid}, 16'd0);
        tick();
        check_eq("lat_e1", {15'd0, out_valid}, 16'd0);
        tick();
        pop_expect("a", 3'd0, 7'h61);
        expect_empty("a");

        // Shifted digit, then unshifted after release
        send(16'h0012, 1'b1);
        send(16'h001E, 1'b1);
        send(16'h0012, 1'b0);
        send(16'h001E, 1'b1);
        settle();
        pop_expect("at", 3'd0, 7'h40);
        pop_expect("two", 3'd0, 7'h32);
        expect_empty("shift");

        // Caps Lock with a typematic repeat, letters vs digits
        send(16'h0058, 1'b1);
        send(16'h0058, 1'b1);
        send(16'h0058, 1'b0);
        check_eq("caps_on", {15'd0, caps_lock}, 16'd1);
        send(16'h0015, 1'b1);
        send(16'h0016, 1'b1);
        settle();
        pop_expect("Q", 3'd0, 7'h51);
        pop_expect("one", 3'd0, 7'h31);
        send(16'h0012, 1'b1);
        send(16'h0015, 1'b1);
        send(16'h0012, 1'b0);
        settle();
        pop_expect("q_shcaps", 3'd0, 7'h71);
        expect_empty("caps");

        // Keypad ignores shift/caps, space is space, breaks and unknowns are silent
        send(16'h0012, 1'b1);
        send(16'hE04A, 1'b1);
        send(16'h0069, 1'b1);
        send(16'h0029, 1'b1);
        send(16'h0012, 1'b0);
        send(16'h001C, 1'b0);
        send(16'h000E, 1'b1);
        settle();
        pop_expect("kp_slash", 3'd0, 7'h2F);
        pop_expect("kp_one", 3'd0, 7'h31);
        pop_expect("space", 3'd0, 7'h20);
        expect_empty("misc");
        check_eq("misc_ovf", {15'd0, overflow}, 16'd0);

        // Navigation keys streamed with the consumer always ready
        out_ready = 1'b1;
        send(16'hE06B, 1'b1);
        send(16'hE071, 1'b1);
        send(16'h005A, 1'b1);
        check_eq("left_kind", {13'd0, out_kind}, 16'd1);
        check_eq("left_sym", {9'd0, out_symbol}, 16'd0);
        tick();
        check_eq("del_kind", {13'd0, out_kind}, 16'd5);
        check_eq("del_sym", {9'd0, out_symbol}, 16'd0);
        tick();
        check_eq("enter_kind", {13'd0, out_kind}, 16'd4);
        check_eq("enter_valid", {15'd0, out_valid}, 16'd1);
        tick();
        out_ready = 1'b0;
        expect_empty("nav");

        // Overflow: DEPTH+1 back-to-back makes with no consumer
        for (int i = 0; i < DEPTH + 1; i++) send(16'h0045, 1'b1);
        settle();
        check_eq("ovf_set", {15'd0, overflow}, 16'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check_eq("ovf_clr", {15'd0, overflow}, 16'd0);
        for (int i = 0; i < DEPTH; i++) pop_expect("zero", 3'd0, 7'h30);
        expect_empty("ovf_drain");

        // Refill, then drop concurrent with clear: set wins
        for (int i = 0; i < DEPTH; i++) send(16'h0045, 1'b1);
        settle();
        check_eq("full_no_ovf", {15'd0, overflow}, 16'd0);
        send(16'h0045, 1'b1);
        tick();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check_eq("ovf_set_wins", {15'd0, overflow}, 16'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;

        // Full plus push and pop in the same cycle
        send(16'h0045, 1'b1);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("pushpop_ovf", {15'd0, overflow}, 16'd0);
        for (int i = 0; i < DEPTH; i++) pop_expect("pp", 3'd0, 7'h30);
        expect_empty("pp");

        // Reset mid-operation with queued events and Caps on
        send(16'h0015, 1'b1);
        send(16'h0016, 1'b1);
        send(16'h001C, 1'b1);
        settle();
        check_eq("pre_rst_valid", {15'd0, out_valid}, 16'd1);
        check_eq("pre_rst_caps", {15'd0, caps_lock}, 16'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst2_valid", {15'd0, out_valid}, 16'd0);
        check_eq("rst2_caps", {15'd0, caps_lock}, 16'd0);
        check_eq("rst2_ovf", {15'd0, overflow}, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send(16'h001C, 1'b1);
        check_eq("post_e0", {15'd0, out_valid}, 16'd0);
        tick();
        check_eq("post_e1", {15'd0, out_valid}, 16'd0);
        tick();
        pop_expect("post_a", 3'd0, 7'h61);
        expect_empty("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event queue depth; SHALL be a power of two, 2..64.
REQ-002 Parameter CAPS_ENABLE, default 1; 1 enables Caps Lock tracking, 0 pins caps state to 0.
REQ-003 clk  in  1  single clock; every flop on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 key  in  16  scan code from ps2_rx: 16'h00xx plain, 16'hE0xx extended.
REQ-006 key_pressed  in  1  1 = make, 0 = break; valid with new_key.
REQ-007 new_key  in  1  one-cycle strobe qualifying key/key_pressed.
REQ-008 out_valid  out  1  event at FIFO head.
REQ-009 out_ready  in  1  consumer accepts head when out_valid & out_ready.
REQ-010 out_kind  out  3  0 SYMBOL, 1 LEFT, 2 RIGHT, 3 BACKSPACE, 4 ENTER, 5 DELETE, 6 HOME, 7 END.
REQ-011 out_symbol  out  7  ASCII when out_kind = SYMBOL, else 0.
REQ-012 caps_lock  out  1  current Caps Lock state, for keyboard LED.
REQ-013 overflow  out  1  sticky: event dropped because FIFO full.
REQ-014 overflow_clr  in  1  clears overflow on next edge.

Function
REQ-015 Stage 1: on new_key, register key, key_pressed, shift and caps state; classify in stage 2; write FIFO at the following edge, so an event strobed at edge E shows out_valid after edge E+2 when the FIFO was empty.
REQ-016 Modifiers: 0x0012 (LShift) and 0x0059 (RShift) set/clear separate held flags on make/break; shift = lshift | rshift; modifiers never produce events.
REQ-017 Caps (0x0058): caps_lock toggles on a make only when caps_held = 0; make sets caps_held and break clears it, so typematic repeats do not toggle.
REQ-018 Only makes enqueue; breaks update modifier state only.
REQ-019 Kind codes: E06B LEFT, E074 RIGHT, 0066 BACKSPACE, 005A and E05A ENTER, E071 DELETE, E06C HOME, E069 END.
REQ-020 Letters (q..p, a..l, z..m row codes) output uppercase when shift XOR caps_lock, else lowercase.
REQ-021 Top-row and punctuation keys use shift only, not caps: 1! 2@ 3# 4$ 5% 6^ 7& 8* 9( 0) -_ =+ [{ ]} ;: ,< .> /?; codes 0x55 '=', 0x4C ';', 0x41 ','.
REQ-022 Space (0x29) gives ' ' in both shift states; keypad codes (7C 7B 6C 75 7D 79 6B 73 74 69 72 7A 70 71, E04A) give the unshifted keypad character regardless of shift/caps, 6B/74/6C/69 plain being keypad digits.
REQ-023 Unrecognised makes are discarded: no FIFO write, no overflow.
REQ-024 FIFO full and push without pop: event dropped, overflow set; full and simultaneous push/pop: both performed, no overflow.
REQ-025 FIFO empty: out_valid = 0 and out_kind/out_symbol = 0; no pop without out_valid.
REQ-026 overflow_clr concurrent with a new drop: overflow stays 1 (set wins).
REQ-027 Sustained new_key every cycle accepted without loss while FIFO not full.

Reset
REQ-028 rst_n low: FIFO empty, pipeline valids 0, shift/caps_held/caps_lock/overflow 0, all outputs 0.
REQ-029 Reset mid-operation discards in-flight and queued events; first post-reset event behaves per REQ-015.

Structure
REQ-030 Package ps2_pkg holds the kind enum, scan-code constants and the ASCII shift-map function.
REQ-031 Sub-module key_fifo (parametrised width/depth sync FIFO, full/empty, simultaneous push/pop); FIFO width 10 = {kind, symbol}.

Verification
REQ-032 Make 0x001C, no modifiers -> one event SYMBOL 'a' (0x61), out_valid 2 cycles after the strobe edge.
REQ-033 Make 0x0012, make 0x001E, break 0x0012, make 0x001E -> '@' then '2'; no event for the shift codes.
REQ-034 Caps make, caps make (repeat), caps break, then 0x0015 and 0x0016 -> caps_lock = 1, 'Q' then '1'; with shift held also, 0x0015 -> 'q'.
REQ-035 E06B, E071, 0x005A with out_ready = 1 -> LEFT, DELETE, ENTER, each with out_symbol = 0.
REQ-036 out_ready = 0, FIFO_DEPTH + 1 makes of 0x0045 -> FIFO_DEPTH '0' events, overflow = 1; overflow_clr -> 0; full plus push/pop same cycle -> no overflow.
REQ-037 rst_n pulsed low with 3 queued events and caps_lock = 1 -> out_valid = 0, caps_lock = 0, overflow = 0 immediately.
